// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared types and helpers for the AXI-Stream weights upsizer
package axis_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } upsizer_state_t;

  localparam int unsigned MAX_LANES = 32;

  // Bit i is set for every lane 0..cnt that belongs to the beat being flushed.
  function automatic logic [MAX_LANES-1:0] lane_keep_mask(input int unsigned cnt);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      m[i] = (i <= cnt);
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_weights_upsizer.sv
// rtl/axis_weights_upsizer.sv - packs narrow weight beats into wide rotator beats
// Optional tkeep protocol checker: AXIS_UPSIZER_CHECK_EN
`ifndef S_WEIGHTS_WIDTH_HF
`define S_WEIGHTS_WIDTH_HF 128
`endif

module axis_weights_upsizer
  import axis_pkg::*;
#(
  parameter int S_WIDTH = 32,
  parameter int M_WIDTH = `S_WEIGHTS_WIDTH_HF,
  parameter int R       = M_WIDTH / S_WIDTH
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [S_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                 s_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [M_WIDTH-1:0]   m_axis_tdata,
  output logic [M_WIDTH/8-1:0] m_axis_tkeep,
  output logic                 m_axis_tlast
`ifdef AXIS_UPSIZER_CHECK_EN
  ,
  output logic                 err_tkeep
`endif
);

  localparam int KB = S_WIDTH / 8;
  localparam int CW = $clog2(R);

  if ((S_WIDTH % 8) != 0 || R < 2 || R > int'(MAX_LANES) || (R & (R - 1)) != 0 ||
      R * S_WIDTH != M_WIDTH) begin : g_bad_cfg
    $error("axis_weights_upsizer: unsupported lane configuration");
  end

  upsizer_state_t              state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [R-1:0][S_WIDTH-1:0]   asm_data_q, asm_data_d;
  logic [R-1:0][KB-1:0]        asm_keep_q, asm_keep_d;
  logic                        last_held_q, last_held_d;
  logic                        rdy_q;
  logic                        m_valid_q, m_valid_d;
  logic [M_WIDTH-1:0]          m_data_q, m_data_d;
  logic [M_WIDTH/8-1:0]        m_keep_q, m_keep_d;
  logic                        m_last_q, m_last_d;

  logic                        accept, completing, out_free, load, load_last;
  logic [R-1:0]                lane_mask;
  logic [R-1:0][S_WIDTH-1:0]   fill_data;
  logic [R-1:0][KB-1:0]        fill_keep;

  // rdy_q keeps the input closed until the first edge after reset release.
  assign s_axis_tready = rdy_q & (state_q == FILL);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign completing    = accept & ((cnt_q == CW'(R - 1)) | s_axis_tlast);
  assign out_free      = ~m_valid_q | m_axis_tready;

  always_comb begin
    asm_data_d = asm_data_q;
    asm_keep_d = asm_keep_q;
    if (accept) begin
      asm_data_d[cnt_q] = s_axis_tdata;
      asm_keep_d[cnt_q] = s_axis_tkeep;
    end
    // Lanes above cnt still hold the previous packet and must be zeroed.
    lane_mask = R'(lane_keep_mask(32'(cnt_q)));
    for (int i = 0; i < R; i++) begin
      fill_data[i] = lane_mask[i] ? asm_data_d[i] : '0;
      fill_keep[i] = lane_mask[i] ? asm_keep_d[i] : '0;
    end

    state_d     = state_q;
    cnt_d       = cnt_q;
    last_held_d = last_held_q;
    load        = 1'b0;
    load_last   = 1'b0;
    case (state_q)
      FILL: begin
        if (completing) begin
          if (out_free) begin
            load      = 1'b1;
            load_last = s_axis_tlast;
            cnt_d     = '0;
          end else begin
            last_held_d = s_axis_tlast;
            state_d     = HOLD;
          end
        end else if (accept) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (out_free) begin
          load      = 1'b1;
          load_last = last_held_q;
          cnt_d     = '0;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = fill_data;
      m_keep_d  = fill_keep;
      m_last_d  = load_last;
    end else if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      asm_data_q  <= '0;
      asm_keep_q  <= '0;
      last_held_q <= 1'b0;
      rdy_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_data_q  <= asm_data_d;
      asm_keep_q  <= asm_keep_d;
      last_held_q <= last_held_d;
      rdy_q       <= 1'b1;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_last_q    <= m_last_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;

`ifdef AXIS_UPSIZER_CHECK_EN
  logic err_q;
  logic keep_contig;
  logic keep_bad;

  assign keep_contig = ((s_axis_tkeep & (s_axis_tkeep + KB'(1))) == '0);
  assign keep_bad    = (~s_axis_tlast & ~(&s_axis_tkeep)) | ~keep_contig;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_q <= 1'b0;
    end else if (accept && keep_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err_tkeep = err_q;
`endif

endmodule

// File: tb/tb_axis_weights_upsizer.sv
// tb/tb_axis_weights_upsizer.sv - directed self-checking bench for axis_weights_upsizer
module tb_axis_weights_upsizer;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         s_tvalid, s_tready, s_tlast;
  logic [31:0]  s_tdata;
  logic [3:0]   s_tkeep;
  logic         m_tvalid, m_tready, m_tlast;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
`ifdef AXIS_UPSIZER_CHECK_EN
  logic         err_tkeep;
`endif

  int checks = 0;
  int failures = 0;
  int stalls = 0;
  bit sender_done;

  logic [127:0] oq_data[$];
  logic [15:0]  oq_keep[$];
  logic         oq_last[$];

  axis_weights_upsizer #(.S_WIDTH(32), .M_WIDTH(128)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast)
`ifdef AXIS_UPSIZER_CHECK_EN
    , .err_tkeep(err_tkeep)
`endif
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (aresetn && m_tvalid && m_tready) begin
      oq_data.push_back(m_tdata);
      oq_keep.push_back(m_tkeep);
      oq_last.push_back(m_tlast);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic clear_q();
    oq_data.delete();
    oq_keep.delete();
    oq_last.delete();
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit acc;
    int n;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
    acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      @(negedge aclk);
      acc = s_tready;
      if (!acc) stalls++;
      @(posedge aclk);
      #1;
      n++;
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout data=%h accepted=%0b required=1", d, acc);
    end
  endtask

  task automatic idle();
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = 4'h0; s_tdata = '0;
  endtask

  function automatic logic [127:0] quad(input int base);
    return {32'(base + 3), 32'(base + 2), 32'(base + 1), 32'(base)};
  endfunction

  task automatic test_reset();
    aresetn = 1'b1; m_tready = 1'b1;
    idle();
    #1 aresetn = 1'b0;
    #2;
    checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL rst_tready got=%b exp=0", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", m_tvalid); end
    checks++; if (m_tdata !== 128'h0) begin failures++; $display("FAIL rst_tdata got=%h exp=0", m_tdata); end
    checks++; if (m_tkeep !== 16'h0 || m_tlast !== 1'b0) begin
      failures++; $display("FAIL rst_keep_last got=%h/%b exp=0000/0", m_tkeep, m_tlast);
    end
    repeat (3) @(posedge aclk);
    #1;
    checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL rst_tready_held got=%b exp=0", s_tready); end
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk);
    #1;
    checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL rst_release_tready got=%b exp=1", s_tready); end
  endtask

  task automatic test_streaming();
    clear_q(); stalls = 0;
    for (int i = 0; i < 8; i++) send(32'(i), 4'hF, i == 7);
    idle();
    wait_cycles(4);
    checks++; if (stalls != 0) begin failures++; $display("FAIL stream_bubbles got=%0d exp=0", stalls); end
    checks++; if (oq_data.size() != 2) begin failures++; $display("FAIL stream_count got=%0d exp=2", oq_data.size()); end
    checks++; if (oq_data[0] !== 128'h00000003_00000002_00000001_00000000 || oq_keep[0] !== 16'hFFFF || oq_last[0] !== 1'b0) begin
      failures++; $display("FAIL stream_beat0 got=%h/%h/%b exp=00000003000000020000000100000000/ffff/0", oq_data[0], oq_keep[0], oq_last[0]);
    end
    checks++; if (oq_data[1] !== 128'h00000007_00000006_00000005_00000004 || oq_keep[1] !== 16'hFFFF || oq_last[1] !== 1'b1) begin
      failures++; $display("FAIL stream_beat1 got=%h/%h/%b exp=00000007000000060000000500000004/ffff/1", oq_data[1], oq_keep[1], oq_last[1]);
    end
  endtask

  task automatic test_partial_flush();
    clear_q();
    for (int i = 0; i < 6; i++) send(32'h10 + 32'(i), 4'hF, i == 5);
    idle();
    wait_cycles(4);
    checks++; if (oq_data.size() != 2) begin failures++; $display("FAIL partial_count got=%0d exp=2", oq_data.size()); end
    checks++; if (oq_data[0] !== 128'h00000013_00000012_00000011_00000010 || oq_last[0] !== 1'b0) begin
      failures++; $display("FAIL partial_beat0 got=%h/%b exp=00000013000000120000001100000010/0", oq_data[0], oq_last[0]);
    end
    checks++; if (oq_data[1] !== 128'h00000000_00000000_00000015_00000014) begin
      failures++; $display("FAIL partial_beat1_data got=%h exp=00000000000000000000001500000014", oq_data[1]);
    end
    checks++; if (oq_keep[1] !== 16'h00FF || oq_last[1] !== 1'b1) begin
      failures++; $display("FAIL partial_beat1_keep got=%h/%b exp=00ff/1", oq_keep[1], oq_last[1]);
    end
  endtask

  task automatic test_single_beat();
    clear_q();
    send(32'hAABBCCDD, 4'h3, 1'b1);
    idle();
    wait_cycles(3);
    checks++; if (oq_data.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", oq_data.size()); end
    checks++; if (oq_data[0] !== 128'h00000000_00000000_00000000_AABBCCDD || oq_keep[0] !== 16'h0003 || oq_last[0] !== 1'b1) begin
      failures++; $display("FAIL single_beat got=%h/%h/%b exp=000000000000000000000000aabbccdd/0003/1", oq_data[0], oq_keep[0], oq_last[0]);
    end
  endtask

  task automatic test_back_pressure();
    int stable_err;
    int n;
    clear_q();
    m_tready = 1'b0;
    sender_done = 1'b0;
    stable_err = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(32'h20 + 32'(i), 4'hF, i == 15);
        idle();
        sender_done = 1'b1;
      end
    join_none
    repeat (20) begin
      @(negedge aclk);
      if (m_tvalid && m_tdata !== 128'h00000023_00000022_00000021_00000020) stable_err++;
    end
    checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL bp_tready_hold got=%b exp=0", s_tready); end
    checks++; if (m_tvalid !== 1'b1) begin failures++; $display("FAIL bp_tvalid_hold got=%b exp=1", m_tvalid); end
    checks++; if (stable_err != 0) begin failures++; $display("FAIL bp_stable got=%0d changes exp=0", stable_err); end
    @(posedge aclk);
    #1 m_tready = 1'b1;
    n = 0;
    while (!sender_done && n < 200) begin
      @(posedge aclk);
      n++;
    end
    wait_cycles(4);
    checks++; if (!sender_done) begin failures++; $display("FAIL bp_sender_done got=0 exp=1"); end
    checks++; if (oq_data.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", oq_data.size()); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (oq_data[j] !== quad(32 + 4 * j) || oq_keep[j] !== 16'hFFFF || oq_last[j] !== (j == 3)) begin
        failures++;
        $display("FAIL bp_beat%0d got=%h/%h/%b exp=%h/ffff/%b", j, oq_data[j], oq_keep[j], oq_last[j], quad(32 + 4 * j), j == 3);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_q();
    for (int i = 0; i < 3; i++) send(32'h30 + 32'(i), 4'hF, 1'b0);
    idle();
    aresetn = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
      failures++; $display("FAIL midrst_async got=%b/%b exp=0/0", m_tvalid, s_tready);
    end
    wait_cycles(2);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) send(32'h40 + 32'(i), 4'hF, i == 3);
    idle();
    wait_cycles(4);
    checks++; if (oq_data.size() != 1) begin failures++; $display("FAIL midrst_count got=%0d exp=1", oq_data.size()); end
    checks++; if (oq_data[0] !== 128'h00000043_00000042_00000041_00000040 || oq_last[0] !== 1'b1) begin
      failures++; $display("FAIL midrst_beat got=%h/%b exp=00000043000000420000004100000040/1", oq_data[0], oq_last[0]);
    end
  endtask

`ifdef AXIS_UPSIZER_CHECK_EN
  task automatic test_checker();
    checks++; if (err_tkeep !== 1'b0) begin failures++; $display("FAIL chk_clean got=%b exp=0", err_tkeep); end
    send(32'h50, 4'h7, 1'b0);
    checks++; if (err_tkeep !== 1'b1) begin failures++; $display("FAIL chk_set got=%b exp=1", err_tkeep); end
    send(32'h51, 4'hF, 1'b1);
    idle();
    wait_cycles(5);
    checks++; if (err_tkeep !== 1'b1) begin failures++; $display("FAIL chk_sticky got=%b exp=1", err_tkeep); end
    aresetn = 1'b0;
    #1;
    checks++; if (err_tkeep !== 1'b0) begin failures++; $display("FAIL chk_reset got=%b exp=0", err_tkeep); end
    @(negedge aclk) aresetn = 1'b1;
    wait_cycles(1);
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_partial_flush();
    test_single_beat();
    test_back_pressure();
    test_reset_mid_packet();
`ifdef AXIS_UPSIZER_CHECK_EN
    test_checker();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
